// File: rtl/score_reader_if.sv
// Bundle of the score_reader control, seven-segment inputs and result outputs.
// master drives requests and patterns; slave is the score_reader itself.
interface score_reader_if;
  logic       enable;
  logic       sample;
  logic       clear_high;
  logic [6:0] HEX5;
  logic [6:0] HEX4;
  logic [6:0] HEX3;
  logic [9:0] score;
  logic       score_valid;
  logic [9:0] high_score;
  logic       new_high;
  logic       dec_err;
  logic       busy;
  logic       overrun;

  modport master (
    output enable, sample, clear_high, HEX5, HEX4, HEX3,
    input  score, score_valid, high_score, new_high, dec_err, busy, overrun
  );

  modport slave (
    input  enable, sample, clear_high, HEX5, HEX4, HEX3,
    output score, score_valid, high_score, new_high, dec_err, busy, overrun
  );
endinterface

// File: rtl/score_reader.sv
// Reads a three-digit score from active-low seven-segment patterns, converts
// it to binary over a fixed 5-cycle pipeline and tracks the high score.
module score_reader #(
  parameter bit BLANK_ZERO = 1'b1
) (
  input logic           clk,
  input logic           reset,
  score_reader_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] ACC    = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  // Returns {valid, digit}; blank (7F) only accepted where allow_blank is set.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg, input logic allow_blank);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h7F:   r = allow_blank ? 5'h10 : 5'h00;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [1:0] state_q, state_d;
  logic [6:0] hex5_q, hex5_d, hex4_q, hex4_d, hex3_q, hex3_d;
  logic [3:0] dig_h_q, dig_h_d, dig_t_q, dig_t_d, dig_o_q, dig_o_d;
  logic [1:0] cnt_q, cnt_d;
  logic [9:0] acc_q, acc_d;
  logic [9:0] score_q, score_d;
  logic [9:0] high_q, high_d;
  logic       score_valid_q, score_valid_d;
  logic       new_high_q, new_high_d;
  logic       dec_err_q, dec_err_d;
  logic       overrun_q, overrun_d;

  logic [4:0] dec_h, dec_t, dec_o;
  logic [3:0] cur_digit;

  assign dec_h = seg_decode(hex5_q, BLANK_ZERO);
  assign dec_t = seg_decode(hex4_q, BLANK_ZERO);
  assign dec_o = seg_decode(hex3_q, 1'b0);

  always_comb begin
    case (cnt_q)
      2'd0:    cur_digit = dig_h_q;
      2'd1:    cur_digit = dig_t_q;
      default: cur_digit = dig_o_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    hex5_d        = hex5_q;
    hex4_d        = hex4_q;
    hex3_d        = hex3_q;
    dig_h_d       = dig_h_q;
    dig_t_d       = dig_t_q;
    dig_o_d       = dig_o_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    score_d       = score_q;
    high_d        = high_q;
    overrun_d     = overrun_q;
    score_valid_d = 1'b0;
    new_high_d    = 1'b0;
    dec_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sample && bus.enable) begin
          hex5_d  = bus.HEX5;
          hex4_d  = bus.HEX4;
          hex3_d  = bus.HEX3;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!(dec_h[4] && dec_t[4] && dec_o[4])) begin
          dec_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          dig_h_d = dec_h[3:0];
          dig_t_d = dec_t[3:0];
          dig_o_d = dec_o[3:0];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q * 10'd10 + {6'b0, cur_digit};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) state_d = REPORT;
      end
      default: begin
        score_d       = acc_q;
        score_valid_d = 1'b1;
        if (acc_q > high_q) begin
          high_d     = acc_q;
          new_high_d = 1'b1;
        end
        state_d = IDLE;
      end
    endcase

    if (bus.sample && (state_q != IDLE)) overrun_d = 1'b1;

    // A clear coinciding with REPORT still lets score update but suppresses the new high.
    if (bus.clear_high) begin
      high_d     = '0;
      new_high_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      hex5_q        <= '0;
      hex4_q        <= '0;
      hex3_q        <= '0;
      dig_h_q       <= '0;
      dig_t_q       <= '0;
      dig_o_q       <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      score_q       <= '0;
      high_q        <= '0;
      score_valid_q <= 1'b0;
      new_high_q    <= 1'b0;
      dec_err_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hex5_q        <= hex5_d;
      hex4_q        <= hex4_d;
      hex3_q        <= hex3_d;
      dig_h_q       <= dig_h_d;
      dig_t_q       <= dig_t_d;
      dig_o_q       <= dig_o_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      score_q       <= score_d;
      high_q        <= high_d;
      score_valid_q <= score_valid_d;
      new_high_q    <= new_high_d;
      dec_err_q     <= dec_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.score       = score_q;
  assign bus.score_valid = score_valid_q;
  assign bus.high_score  = high_q;
  assign bus.new_high    = new_high_q;
  assign bus.dec_err     = dec_err_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.overrun     = overrun_q;

endmodule
